// File: rtl/sys_update_pkg.sv
// Shared definitions for the remote-system-update command sequencer:
// host op codes, sequencer states, core parameter/source codes.
package sys_update_pkg;

  typedef enum logic [1:0] {
    OP_READ     = 2'd0,
    OP_WRITE    = 2'd1,
    OP_RECONFIG = 2'd2,
    OP_WDT_KICK = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STROBE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECFG  = 3'd3,
    ST_KICK   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [2:0] PARAM_STATUS      = 3'b000;
  localparam logic [2:0] PARAM_WDT_VALUE   = 3'b010;
  localparam logic [2:0] PARAM_WDT_EN      = 3'b011;
  localparam logic [2:0] PARAM_PAGE_SEL    = 3'b100;
  localparam logic [2:0] PARAM_CONFIG_MODE = 3'b101;

  localparam logic [1:0] SRC_CURRENT = 2'b00;
  localparam logic [1:0] SRC_PREV1   = 2'b01;
  localparam logic [1:0] SRC_PREV2   = 2'b10;
  localparam logic [1:0] SRC_INPUT   = 2'b11;

  // Down-counter load value for a phase lasting n cycles (counts n-1 .. 0).
  function automatic logic [15:0] cnt_load(input int unsigned n);
    return 16'(n - 1);
  endfunction

endpackage

// File: rtl/sys_update_ctrl.sv
// Sequencer turning single host commands into core strobes/pulses, waiting
// out the core's busy handshake and returning exactly one response per command.
module sys_update_ctrl
  import sys_update_pkg::*;
#(
  parameter int unsigned BUSY_GUARD    = 2,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter int unsigned RECONFIG_HOLD = 16,
  parameter int unsigned WDT_PULSE     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_param,
  input  logic [1:0]  cmd_source,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ru_reset,
  output logic        ru_read_param,
  output logic        ru_write_param,
  output logic [2:0]  ru_param,
  output logic [1:0]  ru_read_source,
  output logic [31:0] ru_data_in,
  output logic        ru_reconfig,
  output logic        ru_reset_timer,
  input  logic        ru_busy,
  input  logic [31:0] ru_data_out
);

  // WAIT loads cnt with the full timeout; cycles with cnt above this are guard cycles.
  localparam logic [15:0] GUARD_LIM = 16'(TIMEOUT_CYC - 1 - BUSY_GUARD);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  op_e         r_op;
  op_e         w_op_nxt;
  logic        w_accept;
  logic [31:0] w_rsp_rdata_nxt;
  logic        w_rsp_err_nxt;

  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rd_strobe;
  logic        r_wr_strobe;
  logic        r_reconfig;
  logic        r_kick;
  logic [2:0]  r_param;
  logic [1:0]  r_source;
  logic [31:0] r_wdata;

  // Next-state, counter and response-capture logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_accept        = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          w_op_nxt = op_e'(cmd_op);
          case (cmd_op)
            OP_READ, OP_WRITE: w_state_nxt = ST_STROBE;
            OP_RECONFIG: begin
              w_state_nxt = ST_RECFG;
              w_cnt_nxt   = cnt_load(RECONFIG_HOLD);
            end
            OP_WDT_KICK: begin
              w_state_nxt = ST_KICK;
              w_cnt_nxt   = cnt_load(WDT_PULSE);
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STROBE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = cnt_load(TIMEOUT_CYC);
      end
      ST_WAIT: begin
        if (r_cnt > GUARD_LIM) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (!ru_busy) begin
          w_state_nxt     = ST_RESP;
          w_rsp_rdata_nxt = (r_op == OP_READ) ? ru_data_out : 32'd0;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_cnt == 16'd0) begin
          w_state_nxt     = ST_RESP;
          w_rsp_rdata_nxt = 32'd0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_RECFG, ST_KICK: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt     = ST_RESP;
          w_rsp_rdata_nxt = 32'd0;
          w_rsp_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State, counter and registered outputs; every output is a function of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_op        <= OP_READ;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_reconfig  <= 1'b0;
      r_kick      <= 1'b0;
      r_param     <= 3'd0;
      r_source    <= 2'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rd_strobe <= (w_state_nxt == ST_STROBE) && (w_op_nxt == OP_READ);
      r_wr_strobe <= (w_state_nxt == ST_STROBE) && (w_op_nxt == OP_WRITE);
      r_reconfig  <= (w_state_nxt == ST_RECFG);
      r_kick      <= (w_state_nxt == ST_KICK);
      if (w_accept) begin
        r_param  <= cmd_param;
        r_source <= cmd_source;
        r_wdata  <= cmd_wdata;
      end else begin
        r_param  <= r_param;
        r_source <= r_source;
        r_wdata  <= r_wdata;
      end
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign ru_reset       = reset;
  assign ru_read_param  = r_rd_strobe;
  assign ru_write_param = r_wr_strobe;
  assign ru_param       = r_param;
  assign ru_read_source = r_source;
  assign ru_data_in     = r_wdata;
  assign ru_reconfig    = r_reconfig;
  assign ru_reset_timer = r_kick;

endmodule

// File: tb/tb_sys_update_ctrl.sv
// Self-checking bench for sys_update_ctrl: directed vector table, reset-in-WAIT
// sequence and randomized commands against a latency/response reference model.
module tb_sys_update_ctrl;
  import sys_update_pkg::*;

  localparam int G  = 2;
  localparam int TO = 32;
  localparam int H  = 16;
  localparam int W  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_param;
  logic [1:0]  cmd_source;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ru_reset;
  logic        ru_read_param;
  logic        ru_write_param;
  logic [2:0]  ru_param;
  logic [1:0]  ru_read_source;
  logic [31:0] ru_data_in;
  logic        ru_reconfig;
  logic        ru_reset_timer;
  logic        ru_busy;
  logic [31:0] ru_data_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] dat [64];

  sys_update_ctrl #(
    .BUSY_GUARD(G), .TIMEOUT_CYC(TO), .RECONFIG_HOLD(H), .WDT_PULSE(W)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_param(cmd_param), .cmd_source(cmd_source), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ru_reset(ru_reset), .ru_read_param(ru_read_param), .ru_write_param(ru_write_param),
    .ru_param(ru_param), .ru_read_source(ru_read_source), .ru_data_in(ru_data_in),
    .ru_reconfig(ru_reconfig), .ru_reset_timer(ru_reset_timer),
    .ru_busy(ru_busy), .ru_data_out(ru_data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: response offset from accept, plus data/err, from the timing rules.
  function automatic void model(input logic [1:0] op, input int blen,
                                output int r, output logic [31:0] rd, output logic er);
    r = 0; rd = 32'd0; er = 1'b0;
    if (op == OP_RECONFIG) begin
      r = H + 1;
    end else if (op == OP_WDT_KICK) begin
      r = W + 1;
    end else begin
      for (int k = 0; k < TO; k++) begin
        int t = 2 + k;
        bit busy = (t >= 2) && (t < 2 + blen);
        if (k >= G && !busy) begin
          r = t + 1;
          rd = (op == OP_READ) ? dat[t] : 32'd0;
          break;
        end
        if (k == TO - 1) begin
          r = t + 1;
          er = 1'b1;
        end
      end
    end
  endfunction

  // Starts at a negedge with the DUT idle; accepts there, checks every cycle up to ready again.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] prm, input logic [1:0] src,
                         input logic [31:0] wd, input int blen,
                         input int r_exp, input logic [31:0] rd_exp, input logic er_exp);
    check("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_param = prm; cmd_source = src; cmd_wdata = wd;
    ru_busy = 1'b0; ru_data_out = dat[0];
    for (int o = 1; o <= r_exp + 1; o++) begin
      @(negedge clock);
      check($sformatf("cmd_ready@%0d", o), {31'd0, cmd_ready}, {31'd0, o == r_exp + 1});
      check($sformatf("ru_read_param@%0d", o), {31'd0, ru_read_param},
            {31'd0, (o == 1) && (op == OP_READ)});
      check($sformatf("ru_write_param@%0d", o), {31'd0, ru_write_param},
            {31'd0, (o == 1) && (op == OP_WRITE)});
      check($sformatf("ru_reconfig@%0d", o), {31'd0, ru_reconfig},
            {31'd0, (op == OP_RECONFIG) && (o <= H)});
      check($sformatf("ru_reset_timer@%0d", o), {31'd0, ru_reset_timer},
            {31'd0, (op == OP_WDT_KICK) && (o <= W)});
      check($sformatf("rsp_valid@%0d", o), {31'd0, rsp_valid}, {31'd0, o == r_exp});
      if (o == r_exp) begin
        check("rsp_rdata", rsp_rdata, rd_exp);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, er_exp});
      end
      check($sformatf("ru_fields@%0d", o), {ru_param, ru_read_source, ru_data_in[26:0]},
            {prm, src, wd[26:0]});
      if (o < r_exp) begin
        cmd_valid  = 1'($urandom);
        cmd_op     = 2'($urandom);
        cmd_param  = 3'($urandom);
        cmd_source = 2'($urandom);
        cmd_wdata  = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      ru_busy = (o >= 2) && (o < 2 + blen);
      ru_data_out = (o < 64) ? dat[o] : 32'd0;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  prm;
    logic [1:0]  src;
    logic [31:0] wd;
    int          blen;
    logic [31:0] dconst;
    int          r;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{OP_READ,     PARAM_STATUS,      SRC_CURRENT, 32'h0000_0000, 0,   32'h0000_0000, 5,  32'h0000_0000, 1'b0};
    vecs[1] = '{OP_READ,     PARAM_WDT_VALUE,   SRC_PREV1,   32'h0000_0000, 7,   32'h1234_5678, 10, 32'h1234_5678, 1'b0};
    vecs[2] = '{OP_WRITE,    PARAM_PAGE_SEL,    SRC_INPUT,   32'h0000_0200, 0,   32'hDEAD_BEEF, 5,  32'h0000_0000, 1'b0};
    vecs[3] = '{OP_READ,     PARAM_CONFIG_MODE, SRC_PREV2,   32'h0000_0000, 100, 32'hAAAA_5555, 34, 32'h0000_0000, 1'b1};
    vecs[4] = '{OP_RECONFIG, PARAM_WDT_EN,      SRC_CURRENT, 32'h0000_0011, 0,   32'h0000_0000, 17, 32'h0000_0000, 1'b0};
    vecs[5] = '{OP_WDT_KICK, PARAM_STATUS,      SRC_PREV1,   32'h0000_0022, 0,   32'h0000_0000, 5,  32'h0000_0000, 1'b0};
    vecs[6] = '{OP_WRITE,    PARAM_WDT_EN,      SRC_CURRENT, 32'h0000_0001, 3,   32'h5A5A_5A5A, 6,  32'h0000_0000, 1'b0};
    vecs[7] = '{OP_READ,     PARAM_STATUS,      SRC_INPUT,   32'h0000_0000, 1,   32'hCAFE_0001, 5,  32'hCAFE_0001, 1'b0};
    vecs[8] = '{OP_READ,     PARAM_PAGE_SEL,    SRC_CURRENT, 32'h0000_0000, 31,  32'h0BAD_F00D, 34, 32'h0BAD_F00D, 1'b0};
    vecs[9] = '{OP_WRITE,    PARAM_WDT_VALUE,   SRC_PREV2,   32'h0000_0abc, 30,  32'h1111_2222, 33, 32'h0000_0000, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_param = 3'd0; cmd_source = 2'd0;
    cmd_wdata = 32'd0; ru_busy = 1'b0; ru_data_out = 32'd0;
    repeat (3) @(negedge clock);
    check("ru_reset_follows", {31'd0, ru_reset}, 32'd1);
    check("reset_outputs", {rsp_valid, rsp_err, ru_read_param, ru_write_param, ru_reconfig,
          ru_reset_timer, ru_param, ru_read_source}, 32'd0);
    check("reset_data", rsp_rdata | ru_data_in, 32'd0);
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    #1 check("ru_reset_low", {31'd0, ru_reset}, 32'd0);
    @(negedge clock);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 64; i++) dat[i] = vecs[v].dconst;
      run_cmd(vecs[v].op, vecs[v].prm, vecs[v].src, vecs[v].wd, vecs[v].blen,
              vecs[v].r, vecs[v].rd, vecs[v].er);
    end

    // Reset while waiting on a stuck-busy read: no response, everything cleared.
    for (int i = 0; i < 64; i++) dat[i] = 32'h7777_0000;
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_param = PARAM_PAGE_SEL; cmd_source = SRC_INPUT;
    cmd_wdata = 32'hFFFF_FFFF;
    for (int o = 1; o <= 4; o++) begin
      @(negedge clock);
      check($sformatf("rst_seq_rsp@%0d", o), {31'd0, rsp_valid}, 32'd0);
      cmd_valid = 1'b0;
      ru_busy = (o >= 2);
    end
    reset = 1'b1;
    #1 check("ru_reset_mid", {31'd0, ru_reset}, 32'd1);
    @(negedge clock);
    check("midrst_outputs", {rsp_valid, rsp_err, ru_read_param, ru_write_param, ru_reconfig,
          ru_reset_timer, ru_param, ru_read_source}, 32'd0);
    check("midrst_data", rsp_rdata | ru_data_in, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0; ru_busy = 1'b0;
    for (int o = 0; o < 8; o++) begin
      @(negedge clock);
      check($sformatf("post_rst_idle@%0d", o), {30'd0, rsp_valid, cmd_ready}, 32'd1);
    end
    for (int i = 0; i < 64; i++) dat[i] = 32'h0;
    run_cmd(vecs[0].op, vecs[0].prm, vecs[0].src, vecs[0].wd, vecs[0].blen,
            vecs[0].r, vecs[0].rd, vecs[0].er);

    // Randomized commands, expectations from the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      int          blen;
      int          r;
      logic [31:0] rd;
      logic        er;
      op = 2'($urandom_range(0, 3));
      blen = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 12));
      for (int i = 0; i < 64; i++) dat[i] = $urandom;
      model(op, blen, r, rd, er);
      run_cmd(op, 3'($urandom), 2'($urandom), $urandom, blen, r, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
